// File: rtl/pn_sync_checker.sv
// Receive-side PN sequence checker: self-synchronises to a maximal-length PN stream,
// flywheels a local copy once locked and accumulates compared-bit and bit-error counts.
module pn_sync_checker #(
    parameter int unsigned width      = 16,
    parameter int unsigned lock_count = 32,
    parameter int unsigned err_window = 64,
    parameter int unsigned err_thresh = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             strobe_i,
    input  logic [width-1:0] mask_i,
    input  logic             pn_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [31:0]      bit_count_o,
    output logic [31:0]      err_count_o
);

    localparam int unsigned FillW  = $clog2(width + 1);
    localparam int unsigned MatchW = $clog2(lock_count + 1);
    localparam int unsigned WinW   = $clog2(err_window + 1);
    localparam int unsigned ErrW   = $clog2(err_thresh + 1);

    localparam logic [FillW-1:0]  FillLast  = FillW'(width - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(lock_count - 1);
    localparam logic [WinW-1:0]   WinLast   = WinW'(err_window - 1);
    localparam logic [ErrW-1:0]   ErrLast   = ErrW'(err_thresh - 1);

    localparam logic [1:0] StFill   = 2'd0;
    localparam logic [1:0] StVerify = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [width-1:0] shifter_q, shifter_d;
    logic [FillW-1:0] fill_cnt_q, fill_cnt_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d;
    logic [WinW-1:0]  win_cnt_q, win_cnt_d;
    logic [ErrW-1:0]  win_err_q, win_err_d;
    logic [31:0]      bit_count_q, bit_count_d;
    logic [31:0]      err_count_q, err_count_d;
    logic             err_q, err_d;

    logic predicted;
    logic mismatch;

    assign predicted = ^(shifter_q & mask_i);
    assign mismatch  = pn_i ^ predicted;

    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;

        if (!ena_i) begin
            state_d     = StFill;
            shifter_d   = '0;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            bit_count_d = '0;
            err_count_d = '0;
        end else if (strobe_i) begin
            case (state_q)
                StFill: begin
                    shifter_d  = {shifter_q[width-2:0], pn_i};
                    fill_cnt_d = fill_cnt_q + FillW'(1);
                    if (fill_cnt_q == FillLast) begin
                        state_d     = StVerify;
                        match_cnt_d = '0;
                    end
                end
                StVerify: begin
                    shifter_d = {shifter_q[width-2:0], pn_i};
                    if (mismatch) begin
                        state_d    = StFill;
                        fill_cnt_d = '0;
                    end else if (shifter_q == '0) begin
                        // An all-zero register trivially predicts zeros; never trust it.
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MatchLast) begin
                        state_d     = StLocked;
                        match_cnt_d = match_cnt_q + MatchW'(1);
                        bit_count_d = '0;
                        err_count_d = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MatchW'(1);
                    end
                end
                StLocked: begin
                    // Flywheel: regenerate locally so channel errors cannot propagate.
                    shifter_d = {shifter_q[width-2:0], predicted};
                    if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
                    win_cnt_d = win_cnt_q + WinW'(1);
                    if (mismatch) begin
                        err_d     = 1'b1;
                        win_err_d = win_err_q + ErrW'(1);
                        if (err_count_q != '1) err_count_d = err_count_q + 32'd1;
                    end
                    if (mismatch && (win_err_q == ErrLast)) begin
                        state_d    = StFill;
                        fill_cnt_d = '0;
                    end else if (win_cnt_q == WinLast) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: begin
                    state_d    = StFill;
                    fill_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StFill;
            shifter_q   <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_count_q <= '0;
            err_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
            err_q       <= err_d;
        end
    end

    assign locked_o    = (state_q == StLocked);
    assign err_o       = err_q;
    assign bit_count_o = bit_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: doc/pn_sync_checker.md
Name: pn_sync_checker

Overview:
- Receive-side companion to the sounder's PN generator: self-synchronises to an incoming maximal-length PN bitstream, declares lock, then flywheels a local copy of the sequence.
- While locked, it counts compared bits and bit errors for BER/sounder-quality measurement.
- Sits after bit slicing in the sounder receive path; uses the same tap mask as the transmit generator.

Parameters:
- width, 16, PN register length; must match the transmit generator.
- lock_count, 32, consecutive correct predictions required to declare lock.
- err_window, 64, length of the loss-of-lock observation window, in strobes.
- err_thresh, 8, errors within one window that force loss of lock.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ena_i  in  1  enable; low forces FILL state and clears all counters (synchronous).
- strobe_i  in  1  pn_i valid this cycle; one bit consumed per strobe.
- mask_i  in  width  tap mask, identical to transmitter mask; static while ena_i high.
- pn_i  in  1  received PN bit.
- locked_o  out  1  high while in LOCKED.
- err_o  out  1  one-cycle pulse, registered, on each mismatch in LOCKED.
- bit_count_o  out  32  strobes compared in current/last lock, saturating.
- err_count_o  out  32  mismatches in current/last lock, saturating.

Behaviour:
- Reset (rst_i high, async): state=FILL, shifter=0, all counters=0, locked_o=0, err_o=0. ena_i low has identical effect, synchronously.
- Sequence model: predicted bit p = ^(shifter & mask_i). shifter[0] holds the most recent bit. Shift is {shifter[width-2:0], newbit}.
- Cycles without strobe_i: no state or counter change; err_o=0.
- FILL:
  - Each strobe shifts pn_i in and increments fill_cnt.
  - On the strobe making fill_cnt==width, go to VERIFY with match_cnt=0.
- VERIFY:
  - Each strobe shifts pn_i in (the received bit, not p).
  - pn_i==p: match_cnt++.
  - pn_i!=p: go to FILL with fill_cnt=0. shifter is kept.
  - All-zero guard: if shifter==0 at the strobe, match_cnt is held at 0 and no lock is possible.
  - On the strobe making match_cnt==lock_count, go to LOCKED.
  - On LOCKED entry: bit_count_o, err_count_o, win_cnt and win_err are cleared.
  - locked_o is high from the clock edge of that strobe.
- LOCKED (flywheel):
  - Each strobe shifts p in, not pn_i, so channel errors do not corrupt the local sequence.
  - bit_count_o++ on every strobe.
  - If pn_i!=p: err_o=1 next cycle, err_count_o++, win_err++.
  - win_cnt++ on every strobe.
  - When win_cnt reaches err_window, both win_cnt and win_err are cleared on that strobe, after the threshold check.
  - When win_err reaches err_thresh (counting the current error), go to FILL with fill_cnt=0 and locked_o=0 on the same edge. bit_count_o and err_count_o hold their last values.
- Saturation: both 32-bit counters stop at 32'hFFFFFFFF.
- ena_i falling mid-lock: immediate FILL, locked_o=0, counters cleared.
- mask_i change while ena_i high: undefined; software toggles ena_i around mask updates.
- err_o is never asserted outside LOCKED.

Test Plan:
- Lock acquisition: reset, ena_i=1, error-free PN from a bench generator with the same mask, strobe every cycle -> locked_o rises at the edge of the 48th strobe (16 fill + 32 verify); err_count_o=0.
- Sparse strobe: same stream, strobe_i every 3rd cycle -> lock after exactly 48 strobes; counters and state frozen on non-strobe cycles.
- Verify-phase error: flip bit 20 of the stream -> return to FILL, no lock at strobe 48; lock at strobe 20+48=68.
- Flywheel BER: after lock, flip 5 isolated bits within 64 strobes -> five err_o pulses, err_count_o=5, locked_o stays 1, no further errors (no error propagation); bit_count_o matches strobes since lock.
- Loss of lock: after lock, feed 8 errors inside one 64-strobe window -> locked_o falls on the 8th error; err_count_o=8 held; relock after 48 clean strobes. 7 errors per window repeatedly -> remains locked.
- All-zero input and resets: constant pn_i=0 for 200 strobes -> never locks. Assert rst_i asynchronously mid-lock -> outputs zero immediately, without a clock edge. Drop ena_i mid-lock -> FILL and counters cleared on the next edge.
